// File: rtl/z16_instr_encoder_if.sv
// Field-bundle input and instruction-memory write port of the Z16 encoder.
// master: bundle producer / memory side (drives fields, valid, mem ready).
// slave:  the encoder (drives ready, write enable, address, data).
interface z16_instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    // field bundle, valid/ready handshake
    logic              i_valid;
    logic              o_ready;
    logic              i_last;
    logic [3:0]        i_opcode;
    logic [3:0]        i_rd;
    logic [3:0]        i_rs1;
    logic [3:0]        i_rs2;
    logic [15:0]       i_imm;
    // instruction-memory write port, we/ready handshake
    logic              o_mem_we;
    logic              i_mem_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;

    modport master (
        output i_valid, i_last, i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_mem_ready,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        input  i_valid, i_last, i_opcode, i_rd, i_rs1, i_rs2, i_imm, i_mem_ready,
        output o_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/z16_instr_encoder.sv
// Purpose: packs opcode/rd/rs1/rs2/imm bundles into Z16 words and writes them to imem.
// Latency: word accepted in cycle N is presented on the write port from cycle N+1.
// Backpressure: o_ready drops when the FIFO is full (independent of i_mem_ready); write held while i_mem_ready=0.
//
// Ports: i_clk, i_rst (sync, active-high), i_start/i_base_addr (program start),
//        bus (z16_instr_encoder_if.slave: bundle input + memory write port),
//        o_done (one-cycle end-of-program pulse), o_err/o_err_cnt (rejected bundles),
//        o_checksum (only when Z16_ENC_CHECKSUM_EN is defined: running sum of written words).
module z16_instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    z16_instr_encoder_if.slave bus,
    output logic              o_done,
    output logic              o_err,
    output logic [7:0]        o_err_cnt
`ifdef Z16_ENC_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              push;
    logic              pop;

    // immediate fits the field when every bit above the field's sign bit matches it
    logic              imm8_ok;
    logic              imm4_ok;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    assign imm8_ok = (&bus.i_imm[15:7]) | ~(|bus.i_imm[15:7]);
    assign imm4_ok = (&bus.i_imm[15:3]) | ~(|bus.i_imm[15:3]);

    // ready deliberately ignores i_mem_ready: a full FIFO never accepts even if it pops this cycle
    assign bus.o_ready = (state_q == ST_RUN) && !fifo_full;
    assign accept      = bus.i_valid && bus.o_ready;
    // illegal bundles complete the handshake but never reach the FIFO
    assign push        = accept && enc_legal;
    assign pop         = bus.o_mem_we && bus.i_mem_ready;

    assign bus.o_mem_we    = !fifo_empty;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];

    // field packing
    always_comb begin
        enc_word  = {bus.i_rs2, bus.i_rs1, bus.i_rd, bus.i_opcode};
        enc_legal = 1'b1;
        case (bus.i_opcode)
            4'h9: begin
                enc_word  = {bus.i_imm[7:0], bus.i_rd, bus.i_opcode};
                enc_legal = imm8_ok;
            end
            4'hA, 4'hC, 4'hD: begin
                enc_word  = {bus.i_imm[3:0], bus.i_rs1, bus.i_rd, bus.i_opcode};
                enc_legal = imm4_ok;
            end
            4'hB: begin
                enc_word  = {bus.i_rs2, bus.i_rs1, bus.i_imm[3:0], bus.i_opcode};
                enc_legal = imm4_ok;
            end
            4'hE, 4'hF: begin
                enc_word  = {8'h00, bus.i_rs2[1:0], bus.i_rs1[1:0], bus.i_opcode};
                enc_legal = (bus.i_rs1[3:2] == 2'b00) && (bus.i_rs2[3:2] == 2'b00);
            end
            default: begin
                enc_word  = {bus.i_rs2, bus.i_rs1, bus.i_rd, bus.i_opcode};
                enc_legal = 1'b1;
            end
        endcase
    end

    // next state and done pulse
    always_comb begin
        state_d = state_q;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && bus.i_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // writes complete in the cycle they are accepted, so empty means nothing in flight
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                    o_done  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone defines validity
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // write address; wraps naturally at 2^ADDR_W
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= '0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            addr_q <= i_base_addr;
        end else if (pop) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // rejected-bundle flag and saturating count, cleared per program
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err     <= 1'b0;
            o_err_cnt <= 8'h00;
        end else if ((state_q == ST_IDLE) && i_start) begin
            o_err     <= 1'b0;
            o_err_cnt <= 8'h00;
        end else if (accept && !enc_legal) begin
            o_err <= 1'b1;
            if (o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'h01;
            end
        end
    end

`ifdef Z16_ENC_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csum_q <= 16'h0000;
        end else if ((state_q == ST_IDLE) && i_start) begin
            csum_q <= 16'h0000;
        end else if (pop) begin
            csum_q <= csum_q + bus.o_mem_wdata;
        end
    end

    assign o_checksum = csum_q;
`endif

endmodule

// File: tb/tb_z16_instr_encoder.sv
// Randomized bench for z16_instr_encoder with a field-level reference model.
module tb_z16_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic              done;
    logic              err;
    logic [7:0]        err_cnt;
`ifdef Z16_ENC_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    always #5 clk = ~clk;

    z16_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    z16_instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .bus         (bus.slave),
        .o_done      (done),
        .o_err       (err),
        .o_err_cnt   (err_cnt)
`ifdef Z16_ENC_CHECKSUM_EN
        ,
        .o_checksum  (csum)
`endif
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic        last;
    } bundle_t;

    bundle_t           drv_q[$];
    logic [15:0]       exp_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [15:0]       log_data[$];

    int                mstate;      // 0 idle, 1 run, 2 drain
    logic [ADDR_W-1:0] m_addr;
    bit                m_err;
    int                m_err_cnt;
    logic [15:0]       m_csum;
    int                rdy_mode;    // 0 random, 1 always ready, 2 never ready
    int                n_checks;
    int                n_fails;
    int                done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference encoding from the field rules, using signed integer ranges
    function automatic void ref_enc(input bundle_t b, output bit legal, output logic [15:0] w);
        int si, op, rd, r1, r2, v;
        si = $signed(b.imm);
        op = int'(b.op);
        rd = int'(b.rd);
        r1 = int'(b.rs1);
        r2 = int'(b.rs2);
        legal = 1'b1;
        if (op <= 8) begin
            v = op + 16 * rd + 256 * r1 + 4096 * r2;
        end else if (op == 9) begin
            legal = (si >= -128) && (si <= 127);
            v = op + 16 * rd + 256 * (si & 255);
        end else if (op == 11) begin
            legal = (si >= -8) && (si <= 7);
            v = op + 16 * (si & 15) + 256 * r1 + 4096 * r2;
        end else if (op >= 14) begin
            legal = (r1 < 4) && (r2 < 4);
            v = op + 16 * (r1 % 4) + 64 * (r2 % 4);
        end else begin
            legal = (si >= -8) && (si <= 7);
            v = op + 16 * rd + 256 * r1 + 4096 * (si & 15);
        end
        w = v[15:0];
    endfunction

    function automatic bundle_t mk(input int op, input int rd, input int r1, input int r2,
                                   input logic [15:0] imm, input bit last);
        bundle_t b;
        b.op = 4'(op); b.rd = 4'(rd); b.rs1 = 4'(r1); b.rs2 = 4'(r2);
        b.imm = imm; b.last = last;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle(input bit last);
        bundle_t b;
        b.op  = 4'($urandom_range(0, 15));
        b.rd  = 4'($urandom);
        b.rs1 = 4'($urandom);
        b.rs2 = 4'($urandom);
        if ($urandom_range(0, 3) == 0) b.imm = 16'($urandom);
        else                           b.imm = 16'(int'($urandom_range(0, 300)) - 150);
        b.last = last;
        return b;
    endfunction

    task automatic apply_inputs();
        if (drv_q.size() > 0) begin
            bus.i_valid  = 1'b1;
            bus.i_opcode = drv_q[0].op;
            bus.i_rd     = drv_q[0].rd;
            bus.i_rs1    = drv_q[0].rs1;
            bus.i_rs2    = drv_q[0].rs2;
            bus.i_imm    = drv_q[0].imm;
            bus.i_last   = drv_q[0].last;
        end else begin
            bus.i_valid = 1'b0;
            bus.i_last  = 1'b0;
        end
        case (rdy_mode)
            0:       bus.i_mem_ready = 1'($urandom_range(0, 1));
            1:       bus.i_mem_ready = 1'b1;
            default: bus.i_mem_ready = 1'b0;
        endcase
    endtask

    // one clock: compare at the negedge, advance the model, drive after the posedge
    task automatic step();
        bit          acc;
        bit          legal;
        logic [15:0] w;
        int          ns;
        acc = 1'b0;
        @(negedge clk);
        check_eq("mem_we", bus.o_mem_we, exp_q.size() != 0);
        check_eq("ready", bus.o_ready, (mstate == 1) && (exp_q.size() < DEPTH));
        check_eq("done", done, (mstate == 2) && (exp_q.size() == 0));
        check_eq("err", err, m_err);
        check_eq("err_cnt", err_cnt, m_err_cnt);
        if (exp_q.size() != 0) begin
            check_eq("mem_addr", bus.o_mem_addr, m_addr);
            check_eq("mem_wdata", bus.o_mem_wdata, exp_q[0]);
        end
`ifdef Z16_ENC_CHECKSUM_EN
        check_eq("checksum", csum, m_csum);
`endif
        if (rst) begin
            exp_q.delete();
            drv_q.delete();
            mstate = 0; m_addr = '0; m_err = 0; m_err_cnt = 0; m_csum = '0;
        end else begin
            if (done) done_cnt++;
            ns = mstate;
            if ((mstate == 0) && start) begin
                ns = 1; m_addr = base; m_err = 0; m_err_cnt = 0; m_csum = '0;
            end
            if ((mstate == 2) && (exp_q.size() == 0)) ns = 0;
            if (bus.o_mem_we && bus.i_mem_ready && (exp_q.size() != 0)) begin
                w = exp_q.pop_front();
                log_addr.push_back(m_addr);
                log_data.push_back(w);
                m_addr = m_addr + 1'b1;
                m_csum = m_csum + w;
            end
            acc = bus.i_valid && bus.o_ready && (drv_q.size() != 0);
            if (acc) begin
                ref_enc(drv_q[0], legal, w);
                if (legal) exp_q.push_back(w);
                else begin
                    m_err = 1'b1;
                    if (m_err_cnt < 255) m_err_cnt++;
                end
                if (drv_q[0].last && (mstate == 1)) ns = 2;
            end
            mstate = ns;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) void'(drv_q.pop_front());
        apply_inputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic start_prog(input logic [ADDR_W-1:0] b);
        base  = b;
        start = 1'b1;
        step();
    endtask

    task automatic run_to_done(input string tag);
        int d0;
        d0 = done_cnt;
        apply_inputs();
        for (int i = 0; i < 400; i++) begin
            step();
            if (done_cnt != d0) break;
        end
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
        step();
        step();
        check_eq({tag, "_no_extra_done"}, done_cnt - d0, 1);
    endtask

    initial begin
        int n0;
        int nb;
        n_checks = 0; n_fails = 0; done_cnt = 0;
        mstate = 0; m_addr = '0; m_err = 0; m_err_cnt = 0; m_csum = '0;
        rdy_mode = 1;
        rst = 1'b1; start = 1'b0; base = '0;
        bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_opcode = '0; bus.i_rd = '0;
        bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_imm = '0; bus.i_mem_ready = 1'b1;

        do_reset(2);
        @(negedge clk);
        check_eq("rst_addr", bus.o_mem_addr, 0);
        check_eq("rst_wdata", bus.o_mem_wdata, 0);
        check_eq("rst_ready", bus.o_ready, 0);
        check_eq("rst_we", bus.o_mem_we, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        @(posedge clk); #1;

        // single R-type word
        start_prog(8'h10);
        drv_q.push_back(mk(0, 1, 2, 3, 16'h0000, 1));
        n0 = log_data.size();
        run_to_done("t1");
        check_eq("t1_nwr", log_data.size() - n0, 1);
        check_eq("t1_addr", log_addr[n0], 8'h10);
        check_eq("t1_data", log_data[n0], 16'h3210);

        // imm8, imm4 B-form, E-form; a start while running is ignored
        start_prog(8'h20);
        base = 8'h80; start = 1'b1; step();
        drv_q.push_back(mk(9, 4, 0, 0, 16'hFFFE, 0));
        drv_q.push_back(mk(11, 0, 2, 3, 16'hFFFF, 0));
        drv_q.push_back(mk(14, 0, 1, 2, 16'h0000, 1));
        n0 = log_data.size();
        run_to_done("t2");
        check_eq("t2_nwr", log_data.size() - n0, 3);
        check_eq("t2_d0", log_data[n0], 16'hFE49);
        check_eq("t2_d1", log_data[n0 + 1], 16'h32FB);
        check_eq("t2_d2", log_data[n0 + 2], 16'h009E);
        check_eq("t2_a2", log_addr[n0 + 2], 8'h22);

        // three illegal bundles, then a legal one at the unchanged address
        start_prog(8'h40);
        drv_q.push_back(mk(10, 1, 1, 0, 16'h0008, 0));
        drv_q.push_back(mk(9, 1, 0, 0, 16'h0080, 0));
        drv_q.push_back(mk(15, 0, 4, 0, 16'h0000, 0));
        drv_q.push_back(mk(1, 5, 6, 7, 16'h0000, 1));
        n0 = log_data.size();
        run_to_done("t3");
        check_eq("t3_err", err, 1);
        check_eq("t3_err_cnt", err_cnt, 3);
        check_eq("t3_nwr", log_data.size() - n0, 1);
        check_eq("t3_addr", log_addr[n0], 8'h40);

        // backpressure: 6 bundles against a stalled memory
        rdy_mode = 2;
        start_prog(8'h60);
        for (int i = 0; i < 6; i++) drv_q.push_back(rnd_bundle(i == 5));
        for (int i = 0; i < 6; i++) drv_q[i].op = 4'(i);
        apply_inputs();
        repeat (10) step();
        check_eq("bp_queued", exp_q.size(), 4);
        check_eq("bp_pending", drv_q.size(), 2);
        check_eq("bp_ready_low", bus.o_ready, 0);
        check_eq("bp_addr_held", bus.o_mem_addr, 8'h60);
        rdy_mode = 1;
        n0 = log_data.size();
        run_to_done("bp");
        check_eq("bp_nwr", log_data.size() - n0, 6);
        check_eq("bp_last_addr", log_addr[n0 + 5], 8'h65);

        // address wrap
        start_prog(8'hFE);
        for (int i = 0; i < 4; i++) drv_q.push_back(mk(i, i, 1, 2, 16'h0000, i == 3));
        n0 = log_data.size();
        run_to_done("wrap");
        check_eq("wrap_a0", log_addr[n0], 8'hFE);
        check_eq("wrap_a1", log_addr[n0 + 1], 8'hFF);
        check_eq("wrap_a2", log_addr[n0 + 2], 8'h00);
        check_eq("wrap_a3", log_addr[n0 + 3], 8'h01);

        // randomized programs with random memory stalls
        rdy_mode = 0;
        for (int p = 0; p < 8; p++) begin
            nb = $urandom_range(3, 12);
            start_prog(8'($urandom));
            for (int i = 0; i < nb; i++) drv_q.push_back(rnd_bundle(i == nb - 1));
            run_to_done("rnd");
        end

        // reset with three words queued
        rdy_mode = 2;
        start_prog(8'h30);
        for (int i = 0; i < 3; i++) drv_q.push_back(mk(2, i, 3, 4, 16'h0000, 0));
        apply_inputs();
        repeat (5) step();
        check_eq("mr_queued", exp_q.size(), 3);
        n0 = done_cnt;
        rdy_mode = 1;
        do_reset(1);
        @(negedge clk);
        check_eq("mr_we_after", bus.o_mem_we, 0);
        @(posedge clk); #1;
        repeat (5) step();
        check_eq("mr_no_done", done_cnt - n0, 0);

        // checksum over two words
        start_prog(8'h00);
        drv_q.push_back(mk(0, 1, 2, 3, 16'h0000, 0));
        drv_q.push_back(mk(9, 4, 0, 0, 16'hFFFE, 1));
        run_to_done("cs");
`ifdef Z16_ENC_CHECKSUM_EN
        check_eq("cs_value", csum, 16'h3059);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
